// File: rtl/led_strip_frame_decoder.sv
// led_strip_frame_decoder
// Recovers APA102-style 32-bit LED frames from an oversampled clock/data
// strip stream. Locks on a run of zero bits, then emits one pixel record per
// 32-bit LED frame and flags malformed headers and stalled streams.
module led_strip_frame_decoder #(
  parameter int NUM_LEDS  = 64,
  parameter int SYNC_BITS = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       led_clk,
  input  logic       led_data,
  output logic       pix_valid,
  output logic [7:0] pix_index,
  output logic [4:0] pix_bright,
  output logic [7:0] pix_blue,
  output logic [7:0] pix_green,
  output logic [7:0] pix_red,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] frame_count
);

  localparam int ZW = $clog2(SYNC_BITS + 1);
  localparam logic [ZW-1:0] ZERO_MAX = ZW'(SYNC_BITS);
  localparam logic [ZW-1:0] ZERO_ONE = ZW'(1);
  localparam logic [8:0]    LAST_PIX = 9'(NUM_LEDS - 1);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_SYNC  = 1'b0,
    ST_PIXEL = 1'b1
  } state_t;

  state_t          state_r;
  logic            led_clk_q;
  logic [ZW-1:0]   zero_cnt_r;
  logic [4:0]      bit_cnt_r;
  logic [8:0]      pix_cnt_r;
  logic [7:0]      tmo_cnt_r;
  logic [30:0]     shift_r;

  logic            bit_ev_s;
  logic [31:0]     word_s;
  logic            hdr_ok_s;
  logic            last_pix_s;
  logic            tmo_hit_s;

  // A bit is taken on the rising edge of the strip clock as seen in clk.
  assign bit_ev_s   = led_clk & ~led_clk_q;
  // Complete LED word as it stands once the current bit is shifted in.
  assign word_s     = {shift_r, led_data};
  assign hdr_ok_s   = (word_s[31:29] == 3'b111);
  assign last_pix_s = (pix_cnt_r == LAST_PIX);
  // The counter would reach TIMEOUT on this idle cycle.
  assign tmo_hit_s  = (tmo_cnt_r == TMO_LAST);

  // Strip clock history; resets high so a clock held high at release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_clk_q <= 1'b1;
    end else begin
      led_clk_q <= led_clk;
    end
  end

  // Frame FSM: start-frame hunt, bit assembly, pixel emission and stall abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_SYNC;
      zero_cnt_r  <= '0;
      bit_cnt_r   <= 5'd0;
      pix_cnt_r   <= 9'd0;
      tmo_cnt_r   <= 8'd0;
      shift_r     <= 31'd0;
      pix_valid   <= 1'b0;
      pix_index   <= 8'd0;
      pix_bright  <= 5'd0;
      pix_blue    <= 8'd0;
      pix_green   <= 8'd0;
      pix_red     <= 8'd0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state_r)
        ST_SYNC: begin
          tmo_cnt_r <= 8'd0;
          if (bit_ev_s) begin
            if (!led_data) begin
              if (zero_cnt_r != ZERO_MAX) begin
                zero_cnt_r <= zero_cnt_r + ZERO_ONE;
              end
            end else if (zero_cnt_r == ZERO_MAX) begin
              // This 1 is already bit 31 of pixel 0.
              state_r    <= ST_PIXEL;
              shift_r    <= 31'd1;
              bit_cnt_r  <= 5'd1;
              pix_cnt_r  <= 9'd0;
              zero_cnt_r <= '0;
            end else begin
              zero_cnt_r <= '0;
            end
          end
        end
        ST_PIXEL: begin
          if (bit_ev_s) begin
            // A bit event always beats a coincident timeout.
            tmo_cnt_r <= 8'd0;
            shift_r   <= word_s[30:0];
            bit_cnt_r <= bit_cnt_r + 5'd1;
            if (bit_cnt_r == 5'd31) begin
              if (!hdr_ok_s) begin
                frame_err  <= 1'b1;
                state_r    <= ST_SYNC;
                zero_cnt_r <= '0;
              end else begin
                pix_valid  <= 1'b1;
                pix_index  <= pix_cnt_r[7:0];
                pix_bright <= word_s[28:24];
                pix_blue   <= word_s[23:16];
                pix_green  <= word_s[15:8];
                pix_red    <= word_s[7:0];
                pix_cnt_r  <= pix_cnt_r + 9'd1;
                if (last_pix_s) begin
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 8'd1;
                  state_r     <= ST_SYNC;
                  zero_cnt_r  <= '0;
                end
              end
            end
          end else if (tmo_hit_s) begin
            // Stalled stream: drop the rest of the frame, emitted pixels stand.
            frame_err  <= 1'b1;
            state_r    <= ST_SYNC;
            zero_cnt_r <= '0;
            tmo_cnt_r  <= 8'd0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r    <= ST_SYNC;
          zero_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_strip_frame_decoder.sv
// Self-checking bench for led_strip_frame_decoder. Two instances share one
// strip stream: a 64-LED decoder and a 1-LED decoder (the latter makes the
// frame_count wrap reachable quickly). A bit-level reference model predicts
// every output each cycle; phase checkpoints pin the model with literals.
module tb_led_strip_frame_decoder;

  localparam int NA = 64;
  localparam int NB = 1;
  localparam int SB = 32;
  localparam int TO = 16;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic led_clk  = 1'b0;
  logic led_data = 1'b0;

  logic       pv   [2];
  logic [7:0] pidx [2];
  logic [4:0] pbr  [2];
  logic [7:0] pbl  [2];
  logic [7:0] pgr  [2];
  logic [7:0] prd  [2];
  logic       fd   [2];
  logic       fe   [2];
  logic [7:0] fc   [2];

  int checks     = 0;
  int failures   = 0;
  int armed      = 0;
  int phase      = 0;
  int seen_phase = 0;

  // reference model state
  int          m_in    [2];
  int          m_zeros [2];
  int          m_nbits [2];
  int          m_pix   [2];
  int          m_idle  [2];
  logic [31:0] m_word  [2];
  logic        m_prev = 1'b1;
  logic        m_ev;
  int e_valid [2];
  int e_index [2];
  int e_bright[2];
  int e_blue  [2];
  int e_green [2];
  int e_red   [2];
  int e_done  [2];
  int e_err   [2];
  int e_count [2];

  int cnt_pv [2];
  int cnt_dn [2];
  int cnt_er [2];
  int base_pv[2];
  int base_dn[2];
  int base_er[2];

  always #5 clk = ~clk;

  led_strip_frame_decoder #(.NUM_LEDS(NA), .SYNC_BITS(SB), .TIMEOUT(TO)) u_dut_a (
    .clk(clk), .reset(reset), .led_clk(led_clk), .led_data(led_data),
    .pix_valid(pv[0]), .pix_index(pidx[0]), .pix_bright(pbr[0]), .pix_blue(pbl[0]),
    .pix_green(pgr[0]), .pix_red(prd[0]), .frame_done(fd[0]), .frame_err(fe[0]),
    .frame_count(fc[0])
  );

  led_strip_frame_decoder #(.NUM_LEDS(NB), .SYNC_BITS(SB), .TIMEOUT(TO)) u_dut_b (
    .clk(clk), .reset(reset), .led_clk(led_clk), .led_data(led_data),
    .pix_valid(pv[1]), .pix_index(pidx[1]), .pix_bright(pbr[1]), .pix_blue(pbl[1]),
    .pix_green(pgr[1]), .pix_red(prd[1]), .frame_done(fd[1]), .frame_err(fe[1]),
    .frame_count(fc[1])
  );

  function automatic int nled(input int i);
    return (i == 0) ? NA : NB;
  endfunction

  function automatic logic [31:0] pat(input int i);
    return {3'b111, 5'(i), 8'(i * 3), 8'hA5, 8'(255 - i)};
  endfunction

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0h exp=%0h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  // One strip bit as seen by decoder i: the word is collected as an integer,
  // fields are cut out arithmetically once 32 bits are in.
  task automatic model_step(input int i);
    e_valid[i] = 0;
    e_done[i]  = 0;
    e_err[i]   = 0;
    if (m_in[i] == 0) begin
      if (m_ev) begin
        if (led_data == 1'b0) begin
          if (m_zeros[i] < SB) m_zeros[i]++;
        end else if (m_zeros[i] == SB) begin
          m_in[i] = 1; m_word[i] = 32'd1; m_nbits[i] = 1;
          m_pix[i] = 0; m_idle[i] = 0; m_zeros[i] = 0;
        end else begin
          m_zeros[i] = 0;
        end
      end
    end else if (m_ev) begin
      m_idle[i]  = 0;
      m_word[i]  = (m_word[i] << 1) | 32'(led_data);
      m_nbits[i] = m_nbits[i] + 1;
      if (m_nbits[i] == 32) begin
        m_nbits[i] = 0;
        if ((m_word[i] >> 29) != 32'd7) begin
          e_err[i] = 1; m_in[i] = 0; m_zeros[i] = 0;
        end else begin
          e_valid[i]  = 1;
          e_index[i]  = m_pix[i] % 256;
          e_bright[i] = int'((m_word[i] >> 24) % 32);
          e_blue[i]   = int'((m_word[i] >> 16) % 256);
          e_green[i]  = int'((m_word[i] >> 8) % 256);
          e_red[i]    = int'(m_word[i] % 256);
          m_pix[i]    = m_pix[i] + 1;
          if (m_pix[i] == nled(i)) begin
            e_done[i]  = 1;
            e_count[i] = (e_count[i] + 1) % 256;
            m_in[i]    = 0;
            m_zeros[i] = 0;
          end
        end
      end
    end else begin
      m_idle[i] = m_idle[i] + 1;
      if (m_idle[i] == TO) begin
        e_err[i] = 1; m_in[i] = 0; m_zeros[i] = 0;
      end
    end
  endtask

  // Reference model, evaluated on the same edge the decoders sample.
  always @(posedge clk) begin
    m_ev = led_clk && !m_prev;
    if (reset) begin
      m_prev = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_in[i] = 0; m_zeros[i] = 0; m_nbits[i] = 0; m_pix[i] = 0; m_idle[i] = 0;
        m_word[i] = 32'd0;
        e_valid[i] = 0; e_index[i] = 0; e_bright[i] = 0; e_blue[i] = 0; e_green[i] = 0;
        e_red[i] = 0; e_done[i] = 0; e_err[i] = 0; e_count[i] = 0;
      end
    end else begin
      m_prev = led_clk;
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Literal expectations closing each directed scenario.
  task automatic phase_checks(input int p);
    int dpv;
    int ddn;
    int der;
    int dpv1;
    int ddn1;
    dpv  = cnt_pv[0] - base_pv[0];
    ddn  = cnt_dn[0] - base_dn[0];
    der  = cnt_er[0] - base_er[0];
    dpv1 = cnt_pv[1] - base_pv[1];
    ddn1 = cnt_dn[1] - base_dn[1];
    case (p)
      1: begin
        chk("nom_pix_count", 0, dpv, 64);   chk("nom_done", 0, ddn, 1);
        chk("nom_err", 0, der, 0);          chk("nom_frame_count", 0, fc[0], 1);
        chk("nom_index", 0, pidx[0], 63);   chk("nom_bright", 0, pbr[0], 16);
        chk("nom_blue", 0, pbl[0], 8'h0F);  chk("nom_green", 0, pgr[0], 0);
        chk("nom_red", 0, prd[0], 0);       chk("nom_frame_count", 1, fc[1], 1);
        chk("nom_pix_count", 1, dpv1, 1);
      end
      2: begin
        chk("short_sync_pix", 0, dpv, 0);   chk("short_sync_err", 0, der, 0);
      end
      3: begin
        chk("resync_pix_count", 0, dpv, 64); chk("resync_done", 0, ddn, 1);
        chk("resync_frame_count", 0, fc[0], 1);
        chk("resync_bright", 0, pbr[0], 31); chk("resync_blue", 0, pbl[0], 8'hBD);
        chk("resync_green", 0, pgr[0], 8'hA5); chk("resync_red", 0, prd[0], 8'hC0);
      end
      4: begin
        chk("badhdr_err", 0, der, 1);       chk("badhdr_pix", 0, dpv, 0);
        chk("badhdr_frame_count", 0, fc[0], 0);
      end
      5: begin
        chk("after_bad_pix", 0, dpv, 1);    chk("after_bad_index", 0, pidx[0], 0);
        chk("after_bad_bright", 0, pbr[0], 31); chk("after_bad_blue", 0, pbl[0], 8'h12);
      end
      6: begin
        chk("stall_err", 0, der, 1);        chk("stall_pix", 0, dpv, 5);
        chk("stall_index", 0, pidx[0], 4);  chk("stall_done", 0, ddn, 0);
      end
      7: begin
        chk("edge_at_limit_err", 0, der, 0); chk("edge_at_limit_pix", 0, dpv, 64);
        chk("edge_at_limit_done", 0, ddn, 1);
      end
      8: begin
        chk("b2b_pix", 0, dpv, 192);        chk("b2b_done", 0, ddn, 3);
        chk("b2b_frame_count", 0, fc[0], 3); chk("b2b_err", 0, der, 0);
      end
      9: begin
        chk("pre_reset_pix", 0, dpv, 20);   chk("pre_reset_index", 0, pidx[0], 19);
      end
      10: begin
        chk("post_reset_no_bit_pix", 0, dpv, 0); chk("post_reset_no_bit_err", 0, der, 0);
      end
      11: begin
        chk("post_reset_pix", 0, dpv, 64);  chk("post_reset_done", 0, ddn, 1);
        chk("post_reset_frame_count", 0, fc[0], 1);
      end
      12: begin
        chk("wrap_pre_count", 1, fc[1], 255); chk("wrap_pre_done", 1, ddn1, 255);
      end
      13: begin
        chk("wrap_count", 1, fc[1], 0);     chk("wrap_done", 1, ddn1, 1);
      end
      default: ;
    endcase
  endtask

  // Compare process: every output of both decoders, every cycle.
  always @(negedge clk) begin
    if (armed != 0) begin
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          chk("rst_pix_valid", i, pv[i], 0);  chk("rst_pix_index", i, pidx[i], 0);
          chk("rst_bright", i, pbr[i], 0);    chk("rst_blue", i, pbl[i], 0);
          chk("rst_green", i, pgr[i], 0);     chk("rst_red", i, prd[i], 0);
          chk("rst_frame_done", i, fd[i], 0); chk("rst_frame_err", i, fe[i], 0);
          chk("rst_frame_count", i, fc[i], 0);
        end else begin
          chk("pix_valid", i, pv[i], e_valid[i]);   chk("pix_index", i, pidx[i], e_index[i]);
          chk("pix_bright", i, pbr[i], e_bright[i]); chk("pix_blue", i, pbl[i], e_blue[i]);
          chk("pix_green", i, pgr[i], e_green[i]);  chk("pix_red", i, prd[i], e_red[i]);
          chk("frame_done", i, fd[i], e_done[i]);   chk("frame_err", i, fe[i], e_err[i]);
          chk("frame_count", i, fc[i], e_count[i]);
          if (pv[i]) cnt_pv[i]++;
          if (fd[i]) cnt_dn[i]++;
          if (fe[i]) cnt_er[i]++;
        end
      end
      if (phase != seen_phase) begin
        seen_phase = phase;
        phase_checks(phase);
        for (int i = 0; i < 2; i++) begin
          base_pv[i] = cnt_pv[i];
          base_dn[i] = cnt_dn[i];
          base_er[i] = cnt_er[i];
        end
      end
    end
  end

  task automatic step(input logic c, input logic d);
    led_clk  = c;
    led_data = d;
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    step(1'b0, b);
    step(1'b1, b);
  endtask

  task automatic send_range(input logic [31:0] w, input int hi, input int lo);
    for (int k = hi; k >= lo; k--) send_bit(w[k]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_range(w, 31, 0);
  endtask

  task automatic send_zeros(input int n);
    repeat (n) send_bit(1'b0);
  endtask

  task automatic hold(input int n);
    repeat (n) step(led_clk, led_data);
  endtask

  task automatic do_reset(input logic lvl);
    led_clk  = lvl;
    led_data = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic end_test(input int p);
    hold(3);
    phase = p;
    hold(1);
  endtask

  initial begin
    @(posedge clk); #2;
    armed = 1;
    hold(2);
    reset = 1'b0;

    // nominal frame
    send_zeros(32);
    repeat (64) send_word(32'hF00F0000);
    send_zeros(64);
    end_test(1);

    // short sync, then proper resync
    do_reset(1'b0);
    send_zeros(31);
    send_word(32'hF0000000);
    end_test(2);
    send_zeros(32);
    for (int i = 0; i < 64; i++) send_word(pat(i));
    send_zeros(64);
    end_test(3);

    // bad header, then a clean start
    do_reset(1'b0);
    send_zeros(32);
    send_word(32'hC0FF0000);
    end_test(4);
    send_zeros(32);
    send_word(32'hFF123456);
    end_test(5);

    // stall inside pixel 5
    do_reset(1'b0);
    send_zeros(32);
    for (int i = 0; i < 5; i++) send_word(32'hE0000000 | 32'(i));
    send_range(32'hE0000005, 31, 22);
    hold(TO + 4);
    end_test(6);

    // next edge lands on the TIMEOUT-th cycle
    do_reset(1'b0);
    send_zeros(32);
    for (int i = 0; i < 5; i++) send_word(32'hE0000000 | 32'(i));
    send_range(32'hE0000005, 31, 22);
    hold(TO - 2);
    send_range(32'hE0000005, 21, 0);
    for (int i = 6; i < 64; i++) send_word(32'hE0000000 | 32'(i));
    send_zeros(64);
    end_test(7);

    // back-to-back frames
    do_reset(1'b0);
    send_zeros(32);
    repeat (3) begin
      for (int i = 0; i < 64; i++) send_word(pat(i));
      send_zeros(64);
    end
    end_test(8);

    // reset mid-frame with strip clock held high through release
    do_reset(1'b0);
    send_zeros(32);
    for (int i = 0; i < 20; i++) send_word(32'hE0000000 | 32'(i));
    send_range(32'hE0000014, 31, 20);
    end_test(9);
    do_reset(1'b1);
    hold(3);
    send_zeros(31);
    send_word(32'hF00F0000);
    end_test(10);
    send_zeros(32);
    for (int i = 0; i < 64; i++) send_word(32'hF00F0000);
    send_zeros(64);
    end_test(11);

    // frame_count wrap on the single-LED decoder
    do_reset(1'b0);
    for (int k = 0; k < 255; k++) begin
      send_zeros(32);
      send_word(32'hE7000000 + 32'(k));
    end
    end_test(12);
    send_zeros(32);
    send_word(32'hE70000FF);
    end_test(13);

    hold(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_strip_frame_decoder.md
Name: led_strip_frame_decoder

Overview:
- Downstream consumer of the LED-matrix serial driver. It decodes the two-wire clock/data stream (APA102-style 32-bit frames) back into per-pixel colour words.
- Used as an on-chip loopback checker and as the front end of a chained-matrix repeater.
- Oversamples the strip clock in the system clock domain, locks on the 32-zero start frame, and emits one pixel record per 32-bit LED frame.
- Flags malformed headers and stalled streams.

Parameters:
- NUM_LEDS, 64, LED frames per display frame (1..256).
- SYNC_BITS, 32, consecutive zero bits required to declare a start frame.
- TIMEOUT, 16, system clocks allowed between strip-clock rising edges while mid-frame (2..255).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- led_clk  input  1  strip clock from the driver, synchronous to clk.
- led_data  input  1  strip data from the driver, valid while led_clk high.
- pix_valid  output  1  one-cycle pulse, pixel fields valid.
- pix_index  output  8  LED position within frame, 0..NUM_LEDS-1.
- pix_bright  output  5  global brightness field, frame bits [28:24].
- pix_blue  output  8  frame bits [23:16].
- pix_green  output  8  frame bits [15:8].
- pix_red  output  8  frame bits [7:0].
- frame_done  output  1  one-cycle pulse after the last pixel of a frame.
- frame_err  output  1  one-cycle pulse on header error or timeout.
- frame_count  output  8  completed frames, wraps 255->0.

Behaviour:
- Reset (async assert, applies on the next posedge after release):
  - All outputs 0; state SYNC; zero count 0; bit count 0; pixel count 0; timeout counter 0.
  - led_clk_q resets to 1, so a high led_clk at reset release is not an edge.
- Edge detect:
  - led_clk_q registers led_clk every cycle.
  - A bit event occurs when led_clk==1 and led_clk_q==0. led_data is sampled in that same cycle.
  - Bits arrive MSB first (frame bit 31 first).
- State SYNC:
  - A 0 bit increments the zero count, saturating at SYNC_BITS.
  - A 1 bit with count < SYNC_BITS resets the count to 0 with no error.
  - A 1 bit with count == SYNC_BITS enters PIXEL. This bit is bit 31 of pixel 0; bit count becomes 1, pixel count 0.
  - Timeout is inactive in SYNC.
- State PIXEL:
  - Each bit shifts into a 32-bit register.
  - On the 32nd bit, if the top 3 bits != 3'b111: frame_err pulses the next cycle, no pix_valid, state returns to SYNC with zero count 0.
  - Otherwise the cycle after the 32nd bit: pix_valid=1, pix_index=pixel count, and the fields are loaded and held until the next pix_valid.
  - Pixel count then increments.
  - When pixel count reaches NUM_LEDS: frame_done pulses in the same cycle as the final pix_valid, frame_count increments, and state returns to SYNC with zero count 0.
  - The end-frame zeros are then counted toward the next start frame, so back-to-back frames need no gap beyond SYNC_BITS zeros.
- Timeout (PIXEL only):
  - The counter clears on every bit event and increments otherwise.
  - Reaching TIMEOUT aborts the frame: frame_err pulses, state goes to SYNC, zero count 0, and partial pixels already emitted stand.
  - If a bit event and TIMEOUT occur in the same cycle, the bit event wins and there is no error.
- Latency: pix_valid is exactly 1 clk after the bit event of the 32nd bit.
- pix_valid, frame_done and frame_err are never asserted for more than one cycle.
- frame_err and pix_valid are never asserted together.
- Reset asserted mid-frame discards the partial frame immediately; no pulses are generated.

Test Plan:
- Nominal frame: driver-format stream of 32 zeros, then 64 frames of 0xF00F0000, then 64 zeros.
  - Expect 64 pix_valid pulses with index 0..63, bright=16, blue=0x0F, green=0, red=0.
  - Expect frame_done together with index 63; frame_count=1.
- Short sync: 31 zeros, then 0xF0000000.
  - Expect no pix_valid and no frame_err.
  - A following 32 zeros plus a valid frame then decodes normally.
- Bad header: 32 zeros, then 0xC0FF0000.
  - Expect frame_err 1 clk after bit 32, no pix_valid, return to SYNC.
- Stall: after 10 bits of pixel 5, hold led_clk constant for TIMEOUT clks.
  - Expect exactly one frame_err and pixels 0..4 only.
  - Repeat with the edge arriving on the TIMEOUT-th cycle; expect no error.
- Back-to-back frames: 3 frames separated only by the 64-zero trailer.
  - Expect 192 pix_valid, 3 frame_done pulses, frame_count=3.
  - Repeat with frame_count preset by 255 frames; expect wrap to 0.
- Reset mid-frame: assert reset during pixel 20, with led_clk high at release.
  - Expect all outputs 0 and no spurious bit from the held-high clock.
  - The next full frame decodes from index 0.
